i2c_codec_responder: RTL and testbench



---
 rtl/i2c_codec_responder.sv | 148 ++++++++++++++
 tb/tb_i2c_codec_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - write-only I2C responder modelling the WM8731 control port
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'b0011010,
  parameter int         NUM_REGS  = 10,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_tick,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  input  logic [6:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ADDR   = 4'd1;
  localparam logic [3:0] S_ACK_A  = 4'd2;
  localparam logic [3:0] S_BYTE1  = 4'd3;
  localparam logic [3:0] S_ACK_1  = 4'd4;
  localparam logic [3:0] S_BYTE2  = 4'd5;
  localparam logic [3:0] S_ACK_2  = 4'd6;
  localparam logic [3:0] S_COMMIT = 4'd7;
  localparam logic [3:0] S_IGNORE = 4'd8;

  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] byte1;
  logic       oe_q;
  logic       in_ack;
  logic [8:0] regs [NUM_REGS];

  // Synchronizers reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 8'd0;
      byte1       <= 8'd0;
      oe_q        <= 1'b0;
      reg_wr_tick <= 1'b0;
      reg_addr    <= 7'd0;
      reg_data    <= 9'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
    end else begin
      reg_wr_tick <= 1'b0;

      // The commit is already decided once COMMIT is reached, even if a bus event lands now.
      if (state == S_COMMIT) begin
        reg_wr_tick <= 1'b1;
        reg_addr    <= byte1[7:1];
        reg_data    <= {byte1[0], shreg};
        if (byte1[7:1] == RESET_REG) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
        end else if (byte1[7:1] < 7'(NUM_REGS)) begin
          regs[byte1[IW:1]] <= {byte1[0], shreg};
        end
      end

      if (start_det) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        oe_q    <= 1'b0;
      end else if (stop_det) begin
        state   <= S_IDLE;
        bit_cnt <= 4'd0;
        oe_q    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR, S_BYTE1, S_BYTE2: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == S_ADDR) begin
                if (shreg == {DEV_ADDR, 1'b0}) begin
                  state <= S_ACK_A;
                  oe_q  <= 1'b1;
                end else begin
                  state <= S_IGNORE;
                end
              end else if (state == S_BYTE1) begin
                byte1 <= shreg;
                state <= S_ACK_1;
                oe_q  <= 1'b1;
              end else begin
                state <= S_ACK_2;
                oe_q  <= 1'b1;
              end
            end
          end
          S_ACK_A, S_ACK_1, S_ACK_2: begin
            if (scl_fall) begin
              oe_q <= 1'b0;
              if (state == S_ACK_A)      state <= S_BYTE1;
              else if (state == S_ACK_1) state <= S_BYTE2;
              else                       state <= S_COMMIT;
            end
          end
          S_COMMIT: state <= S_IGNORE;
          S_IGNORE: ;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ack  = (state == S_ACK_A) || (state == S_ACK_1) || (state == S_ACK_2);
  assign sda_oe  = oe_q & in_ack & ~start_det & ~stop_det;
  assign busy    = (state != S_IDLE);
  assign rd_data = (rd_addr < 7'(NUM_REGS)) ? regs[rd_addr[IW-1:0]] : 9'd0;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - randomized bus-level bench for i2c_codec_responder
module tb_i2c_codec_responder;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, reg_wr_tick, busy;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic [6:0] rd_addr;
  logic [8:0] rd_data;

  i2c_codec_responder dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_wr_tick(reg_wr_tick), .reg_addr(reg_addr), .reg_data(reg_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull SDA low.
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  typedef struct { int a; int d; } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         tick_count = 0;
  int         mregs [10];
  exp_t       exp_q [$];
  exp_t       e;
  bit         oe_seen = 0;
  bit         rd_free = 1;
  logic [6:0] rd_fixed = 7'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_rd(input int a);
    return (a < 10) ? mregs[a] : 0;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      foreach (mregs[i]) mregs[i] = 0;
      exp_q.delete();
    end else begin
      if (sda_oe) oe_seen = 1;
      if (reg_wr_tick) begin
        tick_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", reg_wr_tick, 0);
        end else begin
          e = exp_q.pop_front();
          chk("reg_addr", reg_addr, e.a);
          chk("reg_data", reg_data, e.d);
          if (e.a == 15) foreach (mregs[i]) mregs[i] = 0;
          else if (e.a < 10) mregs[e.a] = e.d;
        end
      end else begin
        chk("rd_data", rd_data, model_rd(int'(rd_addr)));
      end
    end
    rd_addr = rd_free ? 7'($urandom_range(0, 15)) : rd_fixed;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b1; wait_cyc(Q);
  endtask

  task automatic send_bits8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_cyc(Q);
      scl_m = 1'b1; wait_cyc(2 * Q);
      scl_m = 1'b0; wait_cyc(Q);
    end
  endtask

  task automatic ack_clock(output logic ack);
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    ack = sda_in; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits8(b);
    ack_clock(ack);
  endtask

  // mode 0: full packet + STOP, 1: STOP after byte1, 2: leave bus for a repeated START
  task automatic send_packet(input logic [7:0] dev, input int addr, input int data, input int mode);
    logic       a;
    logic [7:0] b1, b2;
    bit         good;
    good = (dev == 8'h34);
    b1 = {7'(addr), data[8]};
    b2 = data[7:0];
    bus_start();
    send_byte(dev, a);
    chk("ack_dev", a, good ? 0 : 1);
    send_byte(b1, a);
    chk("ack_byte1", a, good ? 0 : 1);
    if (mode == 0) begin
      if (good) exp_q.push_back('{addr, data});
      send_byte(b2, a);
      chk("ack_byte2", a, good ? 0 : 1);
      bus_stop();
    end else if (mode == 1) begin
      bus_stop();
    end
    wait_cyc(2);
  endtask

  initial begin
    int         t0;
    logic       a;
    logic [7:0] dev;
    int         r, mode;

    reset = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    rd_free = 0;
    rd_fixed = 7'd4;
    wait_cyc(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_tick", reg_wr_tick, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_data", reg_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);

    t0 = tick_count; oe_seen = 0;
    send_packet(8'h34, 4, 9'h012, 0);
    chk("valid_ticks", tick_count - t0, 1);
    chk("valid_oe_seen", oe_seen, 1);
    chk("valid_reg_addr", reg_addr, 4);
    chk("valid_reg_data", reg_data, 9'h012);
    chk("valid_rd_data", rd_data, 9'h012);

    t0 = tick_count; oe_seen = 0;
    send_packet(8'h36, 4, 9'h1AB, 0);
    chk("badaddr_ticks", tick_count - t0, 0);
    chk("badaddr_oe_seen", oe_seen, 0);
    chk("badaddr_rd_data", rd_data, 9'h012);

    bus_start();
    send_byte(8'h35, a);
    chk("read_ack", a, 1);
    chk("read_busy", busy, 1);
    send_byte(8'h08, a);
    bus_stop();
    wait_cyc(4);
    chk("read_idle_busy", busy, 0);

    t0 = tick_count; rd_fixed = 7'd2;
    send_packet(8'h34, 2, 9'h1FF, 1);
    chk("abort_ticks", tick_count - t0, 0);
    chk("abort_rd_data", rd_data, 0);
    send_packet(8'h34, 2, 9'h1FF, 0);
    chk("after_abort_ticks", tick_count - t0, 1);
    chk("after_abort_rd_data", rd_data, 9'h1FF);

    t0 = tick_count; rd_fixed = 7'd3;
    send_packet(8'h34, 3, 9'h055, 2);
    send_packet(8'h34, 3, 9'h0AA, 0);
    chk("rstart_ticks", tick_count - t0, 1);
    chk("rstart_rd_data", rd_data, 9'h0AA);

    for (int k = 0; k < 10; k++) send_packet(8'h34, k, k * 50 + 7, 0);
    rd_fixed = 7'd9;
    wait_cyc(2);
    chk("preload_rd9", rd_data, 9'd457);
    t0 = tick_count;
    send_packet(8'h34, 15, 0, 0);
    chk("regreset_ticks", tick_count - t0, 1);
    for (int k = 0; k < 11; k++) begin
      rd_fixed = 7'(k);
      wait_cyc(2);
      chk("regreset_rd", rd_data, 0);
    end

    bus_start();
    send_byte(8'h34, a);
    send_bits8(8'h08);
    wait_cyc(2);
    chk("midrst_ack_drive", sda_oe, 1);
    chk("midrst_busy_before", busy, 1);
    sda_m = 1'b1;
    t0 = tick_count;
    reset = 1'b1;
    wait_cyc(1);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    reset = 1'b0;
    wait_cyc(4);
    chk("midrst_ticks", tick_count - t0, 0);
    rd_fixed = 7'd4;
    send_packet(8'h34, 4, 9'h123, 0);
    chk("midrst_after_ticks", tick_count - t0, 1);
    chk("midrst_after_rd", rd_data, 9'h123);

    rd_free = 1;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       dev = 8'h34;
      else if (r == 7) dev = 8'h35;
      else if (r == 8) dev = 8'h36;
      else             dev = 8'($urandom_range(0, 255));
      mode = ($urandom_range(0, 5) < 4 || n == 39) ? 0 : $urandom_range(1, 2);
      send_packet(dev, $urandom_range(0, 15), $urandom_range(0, 511), mode);
    end

    wait_cyc(10);
    chk("pending_commits", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
